// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler that time-shares one external combinational ALU between two
// clients. Each accepted op drives the ALU for EXEC_CYCLES, then returns y to its owner.
module alu_share_ctrl #(
   parameter int unsigned DW          = 8,
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [2:0]    req0_op,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [2:0]    req1_op,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic [DW-1:0] rsp0_data,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [DW-1:0] rsp1_data,
   output logic [2:0]    alu_opcode,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_y,
   output logic          busy
);

   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          last_gnt_q;
   logic          owner_q;
   logic [CW-1:0] cnt_q;
   logic          gnt_c;
   logic          gnt_vld_c;
   logic          accept_c;
   logic          rsp_take_c;

   // Round-robin grant: a lone requester wins, a tie goes to the client not served last
   always_comb begin
      gnt_vld_c = req0_valid | req1_valid;
      gnt_c     = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_c = ~last_gnt_q;
      end else if (req1_valid) begin
         gnt_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = EXEC;
         EXEC:    if (cnt_q == '0) state_d = RESP;
         RESP:    if (rsp_take_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake decode; ready only exists in IDLE so busy clients are never accepted
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = (state_q != IDLE);
      if ((state_q == IDLE) && gnt_vld_c) begin
         req0_ready = ~gnt_c;
         req1_ready = gnt_c;
      end
      accept_c   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
      rsp_take_c = (state_q == RESP) & (owner_q ? rsp1_ready : rsp0_ready);
   end

   // Datapath: ALU operands change only on accept; response data is zero unless valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         cnt_q      <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  alu_opcode <= gnt_c ? req1_op : req0_op;
                  alu_a      <= gnt_c ? req1_a  : req0_a;
                  alu_b      <= gnt_c ? req1_b  : req0_b;
                  owner_q    <= gnt_c;
                  last_gnt_q <= gnt_c;
                  cnt_q      <= CW'(EXEC_CYCLES - 1);
               end
            end
            EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else if (owner_q) begin
                  rsp1_valid <= 1'b1;
                  rsp1_data  <= alu_y;
               end else begin
                  rsp0_valid <= 1'b1;
                  rsp0_data  <= alu_y;
               end
            end
            RESP: begin
               if (rsp_take_c) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  rsp0_data  <= '0;
                  rsp1_data  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (EXEC_CYCLES 1 and 4), each with a bench-side
// ALU model; a scoreboard queues expected results at accept and checks them at response.
module tb_alu_share_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a << 1;
         default: return a >> 1;
      endcase
   endfunction

   // Instance with EXEC_CYCLES=1
   logic [1:0] rv;
   logic [1:0] rrdy;
   logic [2:0] rop [2];
   logic [7:0] ra  [2];
   logic [7:0] rb  [2];
   wire  [1:0] qrdy;
   wire  [1:0] sv;
   wire  [7:0] sd0, sd1;
   wire  [2:0] aop1;
   wire  [7:0] aa1, ab1, ay1;
   wire        busy1;

   assign ay1 = alu_f(aop1, aa1, ab1);

   alu_share_ctrl #(.DW(8), .EXEC_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(rv[0]), .req0_ready(qrdy[0]), .req0_op(rop[0]), .req0_a(ra[0]), .req0_b(rb[0]),
      .req1_valid(rv[1]), .req1_ready(qrdy[1]), .req1_op(rop[1]), .req1_a(ra[1]), .req1_b(rb[1]),
      .rsp0_valid(sv[0]), .rsp0_ready(rrdy[0]), .rsp0_data(sd0),
      .rsp1_valid(sv[1]), .rsp1_ready(rrdy[1]), .rsp1_data(sd1),
      .alu_opcode(aop1), .alu_a(aa1), .alu_b(ab1), .alu_y(ay1), .busy(busy1)
   );

   // Instance with EXEC_CYCLES=4; glitch4 corrupts its ALU output on demand
   logic [1:0] rv4;
   logic [1:0] rrdy4;
   logic [2:0] rop4;
   logic [7:0] ra4, rb4, glitch4;
   wire  [1:0] qrdy4;
   wire  [1:0] sv4;
   wire  [7:0] sd40, sd41;
   wire  [2:0] aop4;
   wire  [7:0] aa4, ab4, ay4;
   wire        busy4;

   assign ay4 = alu_f(aop4, aa4, ab4) ^ glitch4;

   alu_share_ctrl #(.DW(8), .EXEC_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(rv4[0]), .req0_ready(qrdy4[0]), .req0_op(rop4), .req0_a(ra4), .req0_b(rb4),
      .req1_valid(rv4[1]), .req1_ready(qrdy4[1]), .req1_op(rop4), .req1_a(ra4), .req1_b(rb4),
      .rsp0_valid(sv4[0]), .rsp0_ready(rrdy4[0]), .rsp0_data(sd40),
      .rsp1_valid(sv4[1]), .rsp1_ready(rrdy4[1]), .rsp1_data(sd41),
      .alu_opcode(aop4), .alu_a(aa4), .alu_b(ab4), .alu_y(ay4), .busy(busy4)
   );

   // Scoreboard for dut1
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int         acc_cnt [2];
   int         rsp_cnt [2];
   logic [7:0] m_got, m_exp;
   logic       m_have;
   int         exp_last;

   always @(negedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < 2; c++) begin
            m_got = (c == 1) ? sd1 : sd0;
            if (rv[c] && qrdy[c]) begin
               if (c == 0) q0.push_back(alu_f(rop[0], ra[0], rb[0]));
               else        q1.push_back(alu_f(rop[1], ra[1], rb[1]));
               acc_cnt[c]++;
            end
            if (sv[c] && rrdy[c]) begin
               m_have = 1'b0;
               m_exp  = '0;
               if (c == 0 && q0.size() != 0) begin
                  m_exp = q0.pop_front(); m_have = 1'b1;
               end else if (c == 1 && q1.size() != 0) begin
                  m_exp = q1.pop_front(); m_have = 1'b1;
               end
               rsp_cnt[c]++;
               tests++;
               if (!m_have) begin
                  fails++;
                  $display("FAIL sb_extra_rsp%0d: got %h, no result outstanding", c, m_got);
               end else if (m_got !== m_exp) begin
                  fails++;
                  $display("FAIL sb_rsp%0d: got %h, expected %h", c, m_got, m_exp);
               end
            end
            if (!sv[c] && m_got !== 8'h00) begin
               tests++; fails++;
               $display("FAIL rsp%0d_data_idle: got %h while invalid, expected 00", c, m_got);
            end
         end
         if (sv === 2'b11) begin
            tests++; fails++;
            $display("FAIL rsp_both_valid: rsp_valid=%b, expected at most one", sv);
         end
      end
   end

   task automatic issue(input int c, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
      int n;
      @(posedge clk); #1;
      rv[c] = 1'b1; rop[c] = op; ra[c] = a; rb[c] = b;
      n = 0;
      do begin @(negedge clk); n++; end while (!qrdy[c] && n < 400);
      tests++;
      if (!qrdy[c]) begin
         fails++;
         $display("FAIL issue%0d_timeout: ready=%b after %0d cycles, expected 1", c, qrdy[c], n);
      end
      @(posedge clk); #1;
      rv[c] = 1'b0;
   endtask

   task automatic wait_idle1();
      int n = 0;
      do begin @(negedge clk); n++; end while ((busy1 || sv != 2'b00) && n < 200);
      tests++;
      if (busy1) begin
         fails++;
         $display("FAIL idle1_timeout: busy=%b after %0d cycles, expected 0", busy1, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rv = '0; rrdy = 2'b11; rv4 = '0; rrdy4 = 2'b11; glitch4 = '0;
      rop4 = '0; ra4 = '0; rb4 = '0;
      for (int c = 0; c < 2; c++) begin
         rop[c] = '0; ra[c] = '0; rb[c] = '0; acc_cnt[c] = 0; rsp_cnt[c] = 0;
      end
      repeat (3) @(negedge clk);
      tests++;
      if ({qrdy, sv, busy1, aop1, aa1, ab1, sd0, sd1} !== '0) begin
         fails++;
         $display("FAIL reset_dut1: rdy=%b val=%b busy=%b op=%h a=%h b=%h d0=%h d1=%h, expected all 0",
                  qrdy, sv, busy1, aop1, aa1, ab1, sd0, sd1);
      end
      tests++;
      if ({qrdy4, sv4, busy4, aop4, aa4, ab4, sd40, sd41} !== '0) begin
         fails++;
         $display("FAIL reset_dut4: rdy=%b val=%b busy=%b op=%h a=%h b=%h, expected all 0",
                  qrdy4, sv4, busy4, aop4, aa4, ab4);
      end
      rst_n = 1'b1;
      exp_last = 1;
      @(negedge clk);
      tests++;
      if ({busy1, busy4, sv, sv4} !== '0) begin
         fails++;
         $display("FAIL reset_release: busy1=%b busy4=%b, expected idle", busy1, busy4);
      end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      rv[0] = 1'b1; rop[0] = 3'd0; ra[0] = 8'h12; rb[0] = 8'h34;
      @(negedge clk);
      tests++;
      if (qrdy !== 2'b01) begin
         fails++; $display("FAIL single_ready: got %b, expected 01", qrdy);
      end
      @(posedge clk); #1;
      rv[0] = 1'b0;
      @(negedge clk);
      tests++;
      if (aa1 !== 8'h12 || ab1 !== 8'h34 || aop1 !== 3'd0 || busy1 !== 1'b1 || sv !== 2'b00) begin
         fails++;
         $display("FAIL single_exec: a=%h b=%h op=%h busy=%b val=%b, expected 12 34 0 1 00",
                  aa1, ab1, aop1, busy1, sv);
      end
      @(negedge clk);
      tests++;
      if (sv !== 2'b01 || sd0 !== 8'h46 || busy1 !== 1'b1) begin
         fails++;
         $display("FAIL single_rsp: val=%b data=%h busy=%b, expected 01 46 1", sv, sd0, busy1);
      end
      @(negedge clk);
      tests++;
      if (busy1 !== 1'b0 || sv !== 2'b00) begin
         fails++; $display("FAIL single_done: busy=%b val=%b, expected 0 00", busy1, sv);
      end
      exp_last = 0;
   endtask

   task automatic test_tie();
      int g = 0;
      int n = 0;
      int owner = -1;
      logic [1:0] want;
      @(posedge clk); #1;
      rop[0] = 3'd1; ra[0] = 8'h50; rb[0] = 8'h07;
      rop[1] = 3'd2; ra[1] = 8'hF3; rb[1] = 8'h3C;
      rv = 2'b11;
      while (g < 4 && n < 100) begin
         @(negedge clk); n++;
         if (qrdy != 2'b00) begin
            want = (exp_last == 0) ? 2'b10 : 2'b01;
            tests++;
            if (qrdy !== want) begin
               fails++; $display("FAIL tie_grant%0d: got %b, expected %b", g, qrdy, want);
            end
            exp_last = int'(qrdy[1]);
            owner = exp_last;
            g++;
         end
         if (owner >= 0 && sv != 2'b00) begin
            tests++;
            if (sv !== ((owner == 1) ? 2'b10 : 2'b01)) begin
               fails++; $display("FAIL tie_owner: rsp_valid=%b with owner %0d", sv, owner);
            end
         end
      end
      tests++;
      if (g < 4) begin
         fails++; $display("FAIL tie_timeout: %0d grants seen, expected 4", g);
      end
      @(posedge clk); #1;
      rv = 2'b00;
      wait_idle1();
   endtask

   task automatic test_backpressure();
      int n = 0;
      logic [7:0] held;
      rrdy = 2'b10;
      @(posedge clk); #1;
      rv[0] = 1'b1; rop[0] = 3'd3; ra[0] = 8'hA5; rb[0] = 8'h0F;
      @(negedge clk);
      tests++;
      if (qrdy !== 2'b01) begin
         fails++; $display("FAIL bp_accept: got %b, expected 01", qrdy);
      end
      @(posedge clk); #1;
      rv[0] = 1'b0;
      rv[1] = 1'b1; rop[1] = 3'd4; ra[1] = 8'h3C; rb[1] = 8'hFF;
      do begin @(negedge clk); n++; end while (!sv[0] && n < 20);
      held = sd0;
      tests++;
      if (held !== 8'hAF) begin
         fails++; $display("FAIL bp_data: got %h, expected af", held);
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         tests++;
         if (sv[0] !== 1'b1 || sd0 !== held || qrdy[1] !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: val=%b data=%h rdy1=%b, expected 1 %h 0",
                     i, sv[0], sd0, qrdy[1], held);
         end
      end
      @(posedge clk); #1;
      rrdy[0] = 1'b1;
      @(negedge clk);
      tests++;
      if (qrdy[1] !== 1'b0 || sv[0] !== 1'b1) begin
         fails++; $display("FAIL bp_release: rdy1=%b val0=%b, expected 0 1", qrdy[1], sv[0]);
      end
      @(negedge clk);
      tests++;
      if (qrdy[1] !== 1'b1 || sv[0] !== 1'b0) begin
         fails++; $display("FAIL bp_first_idle: rdy1=%b val0=%b, expected 1 0", qrdy[1], sv[0]);
      end
      @(posedge clk); #1;
      rv[1] = 1'b0;
      exp_last = 1;
      wait_idle1();
   endtask

   task automatic test_exec4();
      @(posedge clk); #1;
      rv4 = 2'b01; rop4 = 3'd5; ra4 = 8'h96; rb4 = 8'h11;
      @(negedge clk);
      tests++;
      if (qrdy4 !== 2'b01) begin
         fails++; $display("FAIL ex4_ready: got %b, expected 01", qrdy4);
      end
      @(posedge clk); #1;
      rv4 = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (k == 2) glitch4 = 8'hFF;
         if (k == 3) glitch4 = 8'h00;
         @(negedge clk);
         tests++;
         if (aop4 !== 3'd5 || aa4 !== 8'h96 || ab4 !== 8'h11 || busy4 !== 1'b1) begin
            fails++;
            $display("FAIL ex4_hold%0d: op=%h a=%h b=%h busy=%b, expected 5 96 11 1",
                     k, aop4, aa4, ab4, busy4);
         end
         tests++;
         if (k < 4 && sv4 !== 2'b00) begin
            fails++; $display("FAIL ex4_early%0d: rsp_valid=%b, expected 00", k, sv4);
         end else if (k == 4 && (sv4 !== 2'b01 || sd40 !== 8'h69)) begin
            fails++; $display("FAIL ex4_rsp: val=%b data=%h, expected 01 69", sv4, sd40);
         end
      end
      @(negedge clk);
      tests++;
      if (busy4 !== 1'b0 || sv4 !== 2'b00 || sd40 !== 8'h00) begin
         fails++;
         $display("FAIL ex4_done: busy=%b val=%b data=%h, expected 0 00 00", busy4, sv4, sd40);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      @(posedge clk); #1;
      rv4 = 2'b01; rop4 = 3'd0; ra4 = 8'h21; rb4 = 8'h43;
      @(negedge clk);
      tests++;
      if (qrdy4 !== 2'b01) begin
         fails++; $display("FAIL rmid_accept: got %b, expected 01", qrdy4);
      end
      @(posedge clk); #1;
      rv4 = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      tests++;
      if ({busy4, sv4, aop4, aa4, ab4, sd40, sd41} !== '0) begin
         fails++;
         $display("FAIL rmid_async: busy=%b val=%b op=%h a=%h b=%h, expected all 0",
                  busy4, sv4, aop4, aa4, ab4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_last = 1;
      @(posedge clk); #1;
      rv4 = 2'b11; rop4 = 3'd2; ra4 = 8'hF0; rb4 = 8'h3C;
      @(negedge clk);
      tests++;
      if (qrdy4 !== 2'b01) begin
         fails++; $display("FAIL rmid_tie: got %b, expected 01", qrdy4);
      end
      @(posedge clk); #1;
      rv4 = 2'b00;
      do begin @(negedge clk); n++; end while (busy4 && n < 50);
      tests++;
      if (busy4 !== 1'b0) begin
         fails++; $display("FAIL rmid_drain: busy=%b, expected 0", busy4);
      end
   endtask

   task automatic test_random();
      logic d0 = 1'b0;
      logic d1 = 1'b0;
      for (int c = 0; c < 2; c++) begin
         acc_cnt[c] = 0; rsp_cnt[c] = 0;
      end
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               issue(0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
            end
            d0 = 1'b1;
         end
         begin
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               issue(1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
            end
            d1 = 1'b1;
         end
         begin
            while (!(d0 && d1)) begin
               @(posedge clk); #1;
               rrdy = 2'($urandom_range(0, 3));
            end
         end
      join
      rrdy = 2'b11;
      wait_idle1();
      for (int c = 0; c < 2; c++) begin
         tests++;
         if (acc_cnt[c] != 8 || rsp_cnt[c] != 8) begin
            fails++;
            $display("FAIL rand_count%0d: accepted %0d responded %0d, expected 8 8",
                     c, acc_cnt[c], rsp_cnt[c]);
         end
      end
      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         fails++;
         $display("FAIL rand_lost: %0d/%0d results outstanding, expected 0/0", q0.size(), q1.size());
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_exec4();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
